// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and constants for the DCache data-array arbiter
package dcache_pkg;
    typedef enum logic [1:0] {AG_HR, AG_HW, AG_FL, AG_WB} agent_e;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WBACK} state_e;
    localparam int BURST_BEATS = 4;
endpackage

// File: rtl/dcache_starve_counter.sv
// rtl/dcache_starve_counter.sv - saturating wait counter; at_limit flags a starved requester
module dcache_starve_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             at_limit
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != limit)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == limit);
endmodule

// File: rtl/dcache_data_arbiter.sv
// rtl/dcache_data_arbiter.sv - one-access-per-cycle arbiter for the single-ported DCache data array
module dcache_data_arbiter
    import dcache_pkg::*;
#(
    parameter int INDEX_W      = 6,
    parameter int WAY_W        = 3,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hr_valid,
    output logic                 hr_ready,
    input  logic [INDEX_W-1:0]   hr_index,
    input  logic [WAY_W-1:0]     hr_way,
    input  logic [1:0]           hr_offset,
    output logic                 hr_rvalid,
    output logic [DATA_W-1:0]    hr_rdata,
    input  logic                 hw_valid,
    output logic                 hw_ready,
    input  logic [INDEX_W-1:0]   hw_index,
    input  logic [WAY_W-1:0]     hw_way,
    input  logic [1:0]           hw_offset,
    input  logic [DATA_W/8-1:0]  hw_bwen,
    input  logic [DATA_W-1:0]    hw_wdata,
    input  logic                 fl_valid,
    output logic                 fl_ready,
    input  logic [INDEX_W-1:0]   fl_index,
    input  logic [WAY_W-1:0]     fl_way,
    input  logic [DATA_W-1:0]    fl_wdata,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [INDEX_W-1:0]   wb_index,
    input  logic [WAY_W-1:0]     wb_way,
    output logic                 wb_rvalid,
    output logic [DATA_W-1:0]    wb_rdata,
    output logic                 arr_cen,
    output logic                 arr_wen,
    output logic [WAY_W-1:0]     arr_way,
    output logic [INDEX_W+1:0]   arr_addr,
    output logic [DATA_W/8-1:0]  arr_bwen,
    output logic [DATA_W-1:0]    arr_din,
    input  logic [DATA_W-1:0]    arr_rdata
);
    localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    agent_e     owner_q, owner_d;
    logic       owner_vld_q, owner_vld_d;
    logic       hr_gnt, hw_gnt, fl_gnt, wb_gnt, hr_starved, rd_gnt;

    dcache_starve_counter #(.CNT_W(4)) u_starve (
        .clk      (clock),
        .rst_n    (reset),
        .inc      (hr_valid && !hr_gnt),
        .clr      (!hr_valid || hr_gnt),
        .limit    (4'(STARVE_LIMIT)),
        .at_limit (hr_starved)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The beat counter wraps to 0 on the last beat, so IDLE always starts a burst at offset 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fl_gnt || wb_gnt) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_BEAT) begin
                state_d = ST_IDLE;
            end else if (fl_gnt) begin
                state_d = ST_FILL;
            end else begin
                state_d = ST_WBACK;
            end
        end
    end

    // A locked burst admits only its own agent; a starved hit_read waits for IDLE.
    always_comb begin
        hr_gnt = 1'b0;
        hw_gnt = 1'b0;
        fl_gnt = 1'b0;
        wb_gnt = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (hr_valid && hr_starved) hr_gnt = 1'b1;
                    else if (fl_valid)          fl_gnt = 1'b1;
                    else if (wb_valid)          wb_gnt = 1'b1;
                    else if (hw_valid)          hw_gnt = 1'b1;
                    else if (hr_valid)          hr_gnt = 1'b1;
                end
                ST_FILL:  fl_gnt = fl_valid;
                ST_WBACK: wb_gnt = wb_valid;
                default:  ;
            endcase
        end
    end

    assign hr_ready = hr_gnt;
    assign hw_ready = hw_gnt;
    assign fl_ready = fl_gnt;
    assign wb_ready = wb_gnt;

    always_comb begin
        arr_cen  = hr_gnt | hw_gnt | fl_gnt | wb_gnt;
        arr_wen  = hw_gnt | fl_gnt;
        arr_way  = '0;
        arr_addr = '0;
        arr_bwen = '0;
        arr_din  = '0;
        if (hr_gnt) begin
            arr_way  = hr_way;
            arr_addr = {hr_index, hr_offset};
            arr_bwen = '1;
        end else if (hw_gnt) begin
            arr_way  = hw_way;
            arr_addr = {hw_index, hw_offset};
            arr_bwen = hw_bwen;
            arr_din  = hw_wdata;
        end else if (fl_gnt) begin
            arr_way  = fl_way;
            arr_addr = {fl_index, cnt_q};
            arr_bwen = '1;
            arr_din  = fl_wdata;
        end else if (wb_gnt) begin
            arr_way  = wb_way;
            arr_addr = {wb_index, cnt_q};
            arr_bwen = '1;
        end
    end

    assign rd_gnt = hr_gnt | wb_gnt;

    always_comb begin
        owner_vld_d = rd_gnt;
        owner_d     = owner_q;
        if (rd_gnt) begin
            owner_d = hr_gnt ? AG_HR : AG_WB;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_vld_q <= 1'b0;
            owner_q     <= AG_HR;
        end else begin
            owner_vld_q <= owner_vld_d;
            if (rd_gnt) begin
                owner_q <= owner_d;
            end
        end
    end

    assign hr_rvalid = owner_vld_q && (owner_q == AG_HR);
    assign wb_rvalid = owner_vld_q && (owner_q == AG_WB);
    assign hr_rdata  = hr_rvalid ? arr_rdata : '0;
    assign wb_rdata  = wb_rvalid ? arr_rdata : '0;
endmodule

// File: tb/tb_dcache_data_arbiter.sv
// tb/tb_dcache_data_arbiter.sv - self-checking bench for dcache_data_arbiter
module tb_dcache_data_arbiter;
    localparam int IW = 6;
    localparam int WW = 3;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_HR   = 4'b0001;
    localparam logic [3:0] R_HW   = 4'b0010;
    localparam logic [3:0] R_FL   = 4'b0100;
    localparam logic [3:0] R_WB   = 4'b1000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic hr_valid, hr_ready, hr_rvalid;
    logic [IW-1:0] hr_index;
    logic [WW-1:0] hr_way;
    logic [1:0] hr_offset;
    logic [DW-1:0] hr_rdata;
    logic hw_valid, hw_ready;
    logic [IW-1:0] hw_index;
    logic [WW-1:0] hw_way;
    logic [1:0] hw_offset;
    logic [BW-1:0] hw_bwen;
    logic [DW-1:0] hw_wdata;
    logic fl_valid, fl_ready;
    logic [IW-1:0] fl_index;
    logic [WW-1:0] fl_way;
    logic [DW-1:0] fl_wdata;
    logic wb_valid, wb_ready, wb_rvalid;
    logic [IW-1:0] wb_index;
    logic [WW-1:0] wb_way;
    logic [DW-1:0] wb_rdata;
    logic arr_cen, arr_wen;
    logic [WW-1:0] arr_way;
    logic [IW+1:0] arr_addr;
    logic [BW-1:0] arr_bwen;
    logic [DW-1:0] arr_din;
    logic [DW-1:0] arr_rdata = '0;

    always #5 clock = ~clock;

    dcache_data_arbiter dut (
        .clock(clock), .reset(reset),
        .hr_valid(hr_valid), .hr_ready(hr_ready), .hr_index(hr_index), .hr_way(hr_way),
        .hr_offset(hr_offset), .hr_rvalid(hr_rvalid), .hr_rdata(hr_rdata),
        .hw_valid(hw_valid), .hw_ready(hw_ready), .hw_index(hw_index), .hw_way(hw_way),
        .hw_offset(hw_offset), .hw_bwen(hw_bwen), .hw_wdata(hw_wdata),
        .fl_valid(fl_valid), .fl_ready(fl_ready), .fl_index(fl_index), .fl_way(fl_way),
        .fl_wdata(fl_wdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index), .wb_way(wb_way),
        .wb_rvalid(wb_rvalid), .wb_rdata(wb_rdata),
        .arr_cen(arr_cen), .arr_wen(arr_wen), .arr_way(arr_way), .arr_addr(arr_addr),
        .arr_bwen(arr_bwen), .arr_din(arr_din), .arr_rdata(arr_rdata)
    );

    function automatic logic [DW-1:0] pat(int w, int a);
        return {32'(w), 32'(a), 32'hDEAD0000 | 32'(a), 32'(w * 1000 + a)};
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old_v, logic [DW-1:0] new_v, logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < BW; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Single-ported array model driven purely by the DUT's arr_* outputs.
    logic [DW-1:0] arr_mem [8][256];
    initial begin
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 256; a++)
                arr_mem[w][a] = pat(w, a);
        forever begin
            @(posedge clock);
            if (arr_cen) begin
                if (arr_wen) arr_mem[arr_way][arr_addr] <= merge(arr_mem[arr_way][arr_addr], arr_din, arr_bwen);
                else         arr_rdata <= arr_mem[arr_way][arr_addr];
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic          is_wb;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;
    rd_exp_t sb[$];

    typedef struct {
        logic [3:0]    v;
        logic [IW-1:0] idx;
        logic [WW-1:0] way;
        logic [1:0]    off;
        logic [IW-1:0] bidx;
        logic [WW-1:0] bway;
        logic [3:0]    rdy;
        logic [1:0]    eoff;
    } vec_t;
    vec_t tbl[$];

    logic [DW-1:0] ref_mem [8][256];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(logic [3:0] v, int idx, int way, int off, int bidx, int bway,
                                logic [3:0] rdy, int eoff);
        vec_t t;
        t.v = v; t.idx = IW'(idx); t.way = WW'(way); t.off = 2'(off);
        t.bidx = IW'(bidx); t.bway = WW'(bway); t.rdy = rdy; t.eoff = 2'(eoff);
        return t;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every falling edge also retires due scoreboard entries or checks that no rvalid is raised.
    task automatic neg_edge();
        rd_exp_t e;
        @(negedge clock);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.is_wb) begin
                chk("wb_rvalid", DW'(wb_rvalid), DW'(1'b1));
                chk("wb_rdata", wb_rdata, e.data);
                chk("hr_rvalid_other", DW'(hr_rvalid), '0);
            end else begin
                chk("hr_rvalid", DW'(hr_rvalid), DW'(1'b1));
                chk("hr_rdata", hr_rdata, e.data);
                chk("wb_rvalid_other", DW'(wb_rvalid), '0);
            end
        end else begin
            chk("rvalid_idle", DW'({hr_rvalid, wb_rvalid}), '0);
        end
    endtask

    task automatic apply(vec_t t, string tag);
        logic [WW-1:0] e_way;
        logic [IW+1:0] e_addr;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_din;
        logic          e_wen;
        {wb_valid, fl_valid, hw_valid, hr_valid} = t.v;
        hr_index = t.idx;  hr_way = t.way;  hr_offset = t.off;
        hw_index = t.idx;  hw_way = t.way;  hw_offset = t.off;
        fl_index = t.bidx; fl_way = t.bway;
        wb_index = t.bidx; wb_way = t.bway;
        hw_wdata = {4{32'hC0DE0000 + 32'(cyc)}};
        fl_wdata = {4{32'hF1770000 + 32'(cyc)}};
        neg_edge();
        chk({tag, " ready"}, DW'({wb_ready, fl_ready, hw_ready, hr_ready}), DW'(t.rdy));
        chk({tag, " cen"}, DW'(arr_cen), DW'(t.rdy != R_NONE));
        if (t.rdy != R_NONE) begin
            e_way = t.way; e_addr = {t.idx, t.off}; e_be = '1; e_din = '0; e_wen = 1'b0;
            case (t.rdy)
                R_HR: sb.push_back('{1'b0, ref_mem[e_way][e_addr], cyc + 1});
                R_HW: begin
                    e_be = hw_bwen; e_din = hw_wdata; e_wen = 1'b1;
                    ref_mem[e_way][e_addr] = merge(ref_mem[e_way][e_addr], hw_wdata, hw_bwen);
                end
                R_FL: begin
                    e_way = t.bway; e_addr = {t.bidx, t.eoff}; e_din = fl_wdata; e_wen = 1'b1;
                    ref_mem[e_way][e_addr] = fl_wdata;
                end
                default: begin
                    e_way = t.bway; e_addr = {t.bidx, t.eoff};
                    sb.push_back('{1'b1, ref_mem[e_way][e_addr], cyc + 1});
                end
            endcase
            chk({tag, " way"}, DW'(arr_way), DW'(e_way));
            chk({tag, " addr"}, DW'(arr_addr), DW'(e_addr));
            chk({tag, " wen"}, DW'(arr_wen), DW'(e_wen));
            chk({tag, " bwen"}, DW'(arr_bwen), DW'(e_be));
            chk({tag, " din"}, arr_din, e_din);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int w = 0; w < 8; w++)
            for (int a = 0; a < 256; a++)
                ref_mem[w][a] = pat(w, a);
        {wb_valid, fl_valid, hw_valid, hr_valid} = 4'b1111;
        hr_index = '0; hr_way = '0; hr_offset = '0;
        hw_index = '0; hw_way = '0; hw_offset = '0; hw_bwen = '1; hw_wdata = '0;
        fl_index = '0; fl_way = '0; fl_wdata = '0;
        wb_index = '0; wb_way = '0;

        for (int i = 0; i < 2; i++) begin
            neg_edge();
            chk("reset ready", DW'({wb_ready, fl_ready, hw_ready, hr_ready}), '0);
            chk("reset cen", DW'(arr_cen), '0);
            chk("reset wen", DW'(arr_wen), '0);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Fill burst vs held hits, single read, wback burst with a gap, read-back of fill data.
        tbl.push_back(mk(4'b1111, 3, 1, 2,  9, 5, R_FL, 0));
        tbl.push_back(mk(4'b0111, 3, 1, 2,  9, 5, R_FL, 1));
        tbl.push_back(mk(4'b0111, 3, 1, 2,  9, 5, R_FL, 2));
        tbl.push_back(mk(4'b0111, 3, 1, 2,  9, 5, R_FL, 3));
        tbl.push_back(mk(4'b0011, 3, 1, 2,  9, 5, R_HW, 0));
        tbl.push_back(mk(4'b0001, 3, 1, 2,  9, 5, R_HR, 0));
        tbl.push_back(mk(4'b0001, 5, 2, 1,  9, 5, R_HR, 0));
        tbl.push_back(mk(4'b0000, 5, 2, 1,  9, 5, R_NONE, 0));
        tbl.push_back(mk(4'b1010, 3, 1, 2, 12, 7, R_WB, 0));
        tbl.push_back(mk(4'b1010, 3, 1, 2, 12, 7, R_WB, 1));
        tbl.push_back(mk(4'b0010, 3, 1, 2, 12, 7, R_NONE, 0));
        tbl.push_back(mk(4'b0010, 3, 1, 2, 12, 7, R_NONE, 0));
        tbl.push_back(mk(4'b0010, 3, 1, 2, 12, 7, R_NONE, 0));
        tbl.push_back(mk(4'b1010, 3, 1, 2, 12, 7, R_WB, 2));
        tbl.push_back(mk(4'b1010, 3, 1, 2, 12, 7, R_WB, 3));
        tbl.push_back(mk(4'b0010, 3, 1, 2, 12, 7, R_HW, 0));
        tbl.push_back(mk(4'b0001, 9, 5, 2, 12, 7, R_HR, 0));
        tbl.push_back(mk(4'b0000, 9, 5, 2, 12, 7, R_NONE, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // Starvation: hw wins 8 cycles, then hr beats a simultaneous fill.
        for (int k = 0; k < 8; k++) apply(mk(4'b0011, 20, 3, 0, 30, 6, R_HW, 0), $sformatf("starve%0d", k));
        apply(mk(4'b0111, 20, 3, 0, 30, 6, R_HR, 0), "starve_win");
        for (int k = 0; k < 4; k++) apply(mk(4'b0100, 20, 3, 0, 30, 6, R_FL, k), $sformatf("starve_fill%0d", k));

        // Byte-masked write then read-back.
        hw_bwen = 16'h000F;
        apply(mk(4'b0010, 40, 4, 3, 0, 0, R_HW, 0), "bmask_wr");
        hw_bwen = '1;
        apply(mk(4'b0001, 40, 4, 3, 0, 0, R_HR, 0), "bmask_rd");

        // Reset during a wback burst, right after beat 0 registered its read owner.
        {wb_valid, fl_valid, hw_valid, hr_valid} = 4'b1000;
        wb_index = 6'd50; wb_way = 3'd2;
        neg_edge();
        chk("mid wb_ready", DW'(wb_ready), DW'(1'b1));
        chk("mid addr", DW'(arr_addr), DW'({6'd50, 2'd0}));
        @(posedge clock);
        #1;
        reset = 1'b0;
        neg_edge();
        chk("mid_rst cen", DW'(arr_cen), '0);
        chk("mid_rst wb_ready", DW'(wb_ready), '0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        apply(mk(4'b1100, 0, 0, 0, 50, 2, R_FL, 0), "post_rst0");
        for (int k = 1; k < 4; k++) apply(mk(4'b0100, 0, 0, 0, 50, 2, R_FL, k), $sformatf("post_rst%0d", k));
        apply(mk(4'b0000, 0, 0, 0, 50, 2, R_NONE, 0), "tail");
        neg_edge();
        chk("sb_drained", DW'(sb.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_data_arbiter.md
# dcache_data_arbiter

Arbitrates the four DCache agents (hit_read, hit_write, fill, wback) onto the single-ported, 8-way DCache data array, one access per cycle. Fill and writeback are locked 4-beat bursts with arbiter-generated offsets. A starvation counter bounds hit_read latency. Read data is returned to the winning agent one cycle after its grant.

## Interface
- INDEX_W, 6, set index width
- WAY_W, 3, way select width
- DATA_W, 128, beat width; byte enables are DATA_W/8
- STARVE_LIMIT, 8, waiting cycles after which hit_read jumps to top priority (1..15)

Ports:
- clock  in  1  single clock; everything is on posedge clock
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- hr_valid/hr_ready  in/out  1/1  hit_read request handshake
- hr_index, hr_way, hr_offset  in  INDEX_W/WAY_W/2  hit_read address
- hr_rvalid/hr_rdata  out  1/DATA_W  hit_read response; no backpressure
- hw_valid/hw_ready  in/out  1/1  hit_write request handshake
- hw_index, hw_way, hw_offset, hw_bwen, hw_wdata  in  INDEX_W/WAY_W/2/DATA_W/8/DATA_W  hit_write request
- fl_valid/fl_ready  in/out  1/1  fill beat handshake
- fl_index, fl_way  in  INDEX_W/WAY_W  held stable for the whole burst
- fl_wdata  in  DATA_W  fill beat data
- wb_valid/wb_ready  in/out  1/1  writeback beat handshake
- wb_index, wb_way  in  INDEX_W/WAY_W  held stable for the whole burst
- wb_rvalid/wb_rdata  out  1/DATA_W  writeback beat data; no backpressure
- arr_cen, arr_wen  out  1/1  array access and write strobe
- arr_way, arr_addr  out  WAY_W/INDEX_W+2  way, {index, offset}
- arr_bwen, arr_din  out  DATA_W/8/DATA_W  byte enables and write data
- arr_rdata  in  DATA_W  array read data; valid the cycle after a read

## Operation
- FSM states: IDLE, FILL (fill burst), WBACK (writeback burst). A 2-bit beat counter supplies the burst offset.
- IDLE priority: starved hit_read (starve_cnt == STARVE_LIMIT) > fill > wback > hit_write > hit_read.
- At most one ready is asserted per cycle. Ready is combinational: it equals the grant and is never asserted without the matching valid.
- A fill granted in IDLE is beat 0: offset 0, state goes to FILL, cnt=1.
  - In FILL, only fill is eligible. Each fl_valid is granted with offset=cnt.
  - The grant with cnt==3 returns to IDLE.
  - If fl_valid drops, the array idles and the lock holds.
- WBACK behaves identically for wb_valid. The burst is reads only.
- Array drive on a grant:
  - cen=1.
  - wen=1 for hit_write and fill.
  - bwen is hw_bwen for hit_write, all-ones otherwise.
  - din is hw_wdata or fl_wdata.
  - Without a grant, cen=0 and the other arr_* outputs are don't-care (drive 0).
- Read return: a registered owner tag records the agent of a read grant (hit_read or wback). Next cycle, the owner's rvalid=1 and rdata=arr_rdata. The other agent's rvalid=0.
- starve_cnt:
  - increments when hr_valid && !hr_ready;
  - saturates at STARVE_LIMIT;
  - clears on an hr grant or when hr_valid=0.
- A starved hit_read cannot break an active burst. It wins the first IDLE cycle.

## Timing
- Reset values: state=IDLE, cnt=0, starve_cnt=0, owner tag invalid. All ready and rvalid outputs are 0, arr_cen=0, arr_wen=0.
- Grant-to-array latency is 0, with arr_* combinational from inputs and state. Read data appears at grant+1.
- Back-to-back grants are allowed every cycle. A full burst with continuous valid takes exactly 4 cycles.
- Simultaneous fl_valid and a starved hr_valid in IDLE: hr wins. Fill waits one cycle.
- Reset asserted mid-burst:
  - the burst is abandoned and the FSM is in IDLE on release;
  - a pending rvalid for the next cycle is suppressed.

## Structure
- dcache_pkg holds:
  - the agent enum (AG_HR, AG_HW, AG_FL, AG_WB);
  - the FSM state enum;
  - BURST_BEATS=4.
- One sub-module is natural: dcache_starve_counter, a saturating counter with inc/clr/limit inputs.
- Build the read owner and rvalid with dff_en-style flops using async active-low reset.

## Test plan
- **Reset:** hold reset=0 with all valids high, so all ready, rvalid and arr_cen are 0. Release reset, and the fill is granted first.
- **Single read:** hr_valid, index=5, way=2, offset=1 gives arr_addr=0x15, arr_way=2, wen=0. The next cycle, hr_rvalid=1 with hr_rdata equal to the model contents.
- **Fill burst vs hits:**
  - fl_valid continuous with hw_valid and hr_valid held gives offsets 0,1,2,3 on 4 fill grants;
  - then hw is granted, then hr;
  - arr_bwen=0xFFFF throughout the fill.
- **Burst gap:** wback burst with wb_valid low after beat 1 for 3 cycles, while hw_valid is high. hw_ready stays 0, and beats 2 and 3 resume with offsets 2 and 3. wb_rvalid follows each grant by 1 cycle.
- **Starvation:**
  - STARVE_LIMIT=8;
  - hw_valid is continuous;
  - hr_valid is asserted at cycle 0;
  - hr is granted at cycle 8, ahead of a simultaneous fl_valid.
- **Byte-mask write:** hw_bwen=0x000F, wdata pattern. A read-back shows only bytes 0..3 changed.
